// File: rtl/pipe_pkg.sv
// Shared widths and bundle layout for inter-stage pipeline registers.
// Default widths match the decode->readreg stage.
package pipe_pkg;

  localparam int CTRL_W    = 22;
  localparam int REG_IDX_W = 3;
  localparam int IMM_W     = 16;
  localparam int TYPE_W    = 6;
  localparam int LOAD_BIT  = 8;

  typedef struct packed {
    logic [CTRL_W-1:0]    control;
    logic [REG_IDX_W-1:0] rm;
    logic [REG_IDX_W-1:0] rn;
    logic [REG_IDX_W-1:0] rd;
    logic [IMM_W-1:0]     imm;
    logic [2:0]           used;
    logic [TYPE_W-1:0]    itype;
  } pipe_bundle_t;

  localparam int BUNDLE_W = $bits(pipe_bundle_t);

endpackage

// File: rtl/pipe_entry.sv
// One bundle register plus valid bit, with load and clear.
// Clear wins over load; reset (active-low) zeroes payload too.
module pipe_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         valid_o
);

  logic         data_en;
  logic [W-1:0] data_d;
  logic         valid_en;
  logic         valid_d;

  // flush clears only the valid bit, payload is held
  assign data_en  = !rst_i | load_i;
  assign data_d   = rst_i ? d_i : '0;
  assign valid_en = !rst_i | load_i | clr_i;
  assign valid_d  = rst_i & !clr_i & load_i;

  vDFF_en #(.N(W)) u_data (
    .clk (clk),
    .en  (data_en),
    .d   (data_d),
    .q   (q_o)
  );

  vDFF_en #(.N(1)) u_valid (
    .clk (clk),
    .en  (valid_en),
    .d   (valid_d),
    .q   (valid_o)
  );

endmodule

// File: rtl/vDFF_en.sv
// Plain N-bit register with load enable.
// Reset and clear policy belong to the caller.
module vDFF_en #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk) begin
    if (en) q <= d;
  end

endmodule

// File: rtl/pipeline_stage_skid.sv
// Valid/ready pipeline register for one decoded bundle, with flush.
// PIPE_STAGE_SKID_EN adds a skid entry so in_ready is purely registered.
module pipeline_stage_skid #(
  parameter int CTRL_W    = pipe_pkg::CTRL_W,
  parameter int REG_IDX_W = pipe_pkg::REG_IDX_W,
  parameter int IMM_W     = pipe_pkg::IMM_W,
  parameter int TYPE_W    = pipe_pkg::TYPE_W,
  parameter int LOAD_BIT  = pipe_pkg::LOAD_BIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CTRL_W-1:0]    control_in,
  input  logic [REG_IDX_W-1:0] num_Rm_in,
  input  logic [REG_IDX_W-1:0] num_Rn_in,
  input  logic [REG_IDX_W-1:0] num_Rd_in,
  input  logic [IMM_W-1:0]     imm_in,
  input  logic [2:0]           used_RmRnRd_in,
  input  logic [TYPE_W-1:0]    inst_type_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CTRL_W-1:0]    control_out,
  output logic [REG_IDX_W-1:0] num_Rm_out,
  output logic [REG_IDX_W-1:0] num_Rn_out,
  output logic [REG_IDX_W-1:0] num_Rd_out,
  output logic [IMM_W-1:0]     imm_out,
  output logic [2:0]           used_RmRnRd_out,
  output logic [TYPE_W-1:0]    inst_type_out,
  output logic                 loads,
  output logic [1:0]           occupancy
);

  localparam int BW =
    CTRL_W + 3 * REG_IDX_W + IMM_W + 3 + TYPE_W;

  logic [BW-1:0] in_bus;
  logic [BW-1:0] main_d;
  logic [BW-1:0] main_q;
  logic          main_v;
  logic          main_ld;
  logic          main_clr;
  logic          accept;
  logic          issue;

  assign in_bus = {control_in, num_Rm_in, num_Rn_in,
                   num_Rd_in, imm_in, used_RmRnRd_in,
                   inst_type_in};

  assign accept = in_valid & in_ready;
  assign issue  = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic [BW-1:0] skid_q;
  logic          skid_v;
  logic          skid_ld;
  logic          skid_clr;

  assign in_ready = !skid_v;

  // skid_v implies no accept, so main_d can key off skid_v alone
  always_comb begin
    main_d   = skid_v ? skid_q : in_bus;
    main_ld  = 1'b0;
    main_clr = flush;
    skid_ld  = 1'b0;
    skid_clr = flush;
    if (!flush) begin
      main_ld  = (skid_v & issue)
               | (accept & (!main_v | issue));
      main_clr = issue & !main_ld;
      skid_ld  = accept & main_v & !issue;
      skid_clr = skid_v & issue;
    end
  end

  pipe_entry #(.W(BW)) u_skid (
    .clk     (clk),
    .rst_i   (rst),
    .load_i  (skid_ld),
    .clr_i   (skid_clr),
    .d_i     (in_bus),
    .q_o     (skid_q),
    .valid_o (skid_v)
  );

  assign occupancy = {1'b0, main_v} + {1'b0, skid_v};
`else
  assign in_ready = !main_v | out_ready;

  always_comb begin
    main_d   = in_bus;
    main_ld  = 1'b0;
    main_clr = flush;
    if (!flush) begin
      main_ld  = accept;
      main_clr = issue & !accept;
    end
  end

  assign occupancy = {1'b0, main_v};
`endif

  pipe_entry #(.W(BW)) u_main (
    .clk     (clk),
    .rst_i   (rst),
    .load_i  (main_ld),
    .clr_i   (main_clr),
    .d_i     (main_d),
    .q_o     (main_q),
    .valid_o (main_v)
  );

  assign out_valid = main_v;

  assign {control_out, num_Rm_out, num_Rn_out,
          num_Rd_out, imm_out, used_RmRnRd_out,
          inst_type_out} = main_q;

  assign loads = out_valid & control_out[LOAD_BIT];

endmodule

// File: doc/pipeline_stage_skid.md
# pipeline_stage_skid

Parametrised successor to the fixed-width decode→read-register pipeline register. It carries one instruction's decoded bundle (control word, Rm/Rn/Rd numbers, immediate, register-use mask, instruction type) between two pipeline stages. It replaces the bare `update` enable with a valid/ready handshake, adds a flush that inserts bubbles, and adds an optional skid entry so `in_ready` has no combinational path from `out_ready`. It is instantiated between every pair of stages, starting with decode→readreg.

## Interface
Parameters:
- `CTRL_W`, 22: control word width.
- `REG_IDX_W`, 3: register-number width (Rm, Rn, Rd).
- `IMM_W`, 16: immediate width.
- `TYPE_W`, 6: instruction-type width.
- `LOAD_BIT`, 8: index in control word that marks a load; must be < `CTRL_W`.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst`, in, 1: synchronous, active-low reset.
- `flush`, in, 1: discard all held entries and the same-cycle input.
- `in_valid`, in, 1: upstream bundle valid.
- `in_ready`, out, 1: stage can accept.
- `control_in`, in, `CTRL_W`.
- `num_Rm_in`, `num_Rn_in`, `num_Rd_in`, in, `REG_IDX_W` each.
- `imm_in`, in, `IMM_W`.
- `used_RmRnRd_in`, in, 3: Rm/Rn/Rd use mask.
- `inst_type_in`, in, `TYPE_W`.
- `out_valid`, out, 1: output bundle valid.
- `out_ready`, in, 1: downstream accepts.
- `control_out`, `num_Rm_out`, `num_Rn_out`, `num_Rd_out`, `imm_out`, `used_RmRnRd_out`, `inst_type_out`, out: these mirror the inputs.
- `loads`, out, 1: `out_valid & control_out[LOAD_BIT]`.
- `occupancy`, out, 2: number of held bundles, 0..2.

## Operation
- Accept fires when `in_valid & in_ready`. Issue fires when `out_valid & out_ready`.
- Storage: the main entry (drives the outputs) and the skid entry. Each entry has its own valid bit.
- No issue or issue pending with main empty: an accepted bundle loads main.
- Main full, issue this cycle, skid empty: an accepted bundle loads main, replacing the issued one.
- Main full, no issue, skid empty: an accepted bundle loads skid. `in_ready` then drops.
- Issue while skid full: skid moves to main and skid empties. There is no accept this cycle, because `in_ready` = 0.
- `in_ready` = `!skid_valid`. It depends only on registered state.
- `flush` (with `rst` high): both valid bits are 0 next cycle, and an accept in the same cycle is dropped. Payload registers hold their contents. Flush takes priority over accept and issue. An issue in the same cycle still counts as delivered downstream.
- Order is strict FIFO and bundles are never duplicated.
- `loads` is gated by `out_valid`, so a bubble never reports a load.

## Timing
- Reset: while `rst` = 0 at a rising edge, the next state has both valids 0 and all payload registers 0. After that edge: `out_valid` = 0, `loads` = 0, `occupancy` = 0, `in_ready` = 1, all `*_out` = 0.
- Latency: an accept at edge N gives `out_valid` = 1 with that payload after edge N, i.e. one cycle.
- Throughput: one bundle per cycle while `out_ready` = 1.
- `out_ready` may depend combinationally on `out_valid`. `in_valid` must not depend on `in_ready` within the same cycle.
- Once asserted, `out_valid` and the payload stay stable until issue or flush.

## Configuration
- `PIPE_STAGE_SKID_EN` defined: the two-entry behaviour above applies and `occupancy` ranges over 0..2.
- `PIPE_STAGE_SKID_EN` undefined: there is no skid entry. `in_ready` = `!out_valid | out_ready`, a combinational path from `out_ready`. `occupancy` ranges over 0..1. All other rules are unchanged.

## Structure
- Shared package `pipe_pkg` holds:
  - the default width constants (`CTRL_W`, `REG_IDX_W`, `IMM_W`, `TYPE_W`, `LOAD_BIT`);
  - a packed struct typedef of the bundle, `pipe_bundle_t`.
- Sub-module `pipe_entry`: one bundle register plus valid bit, with load/clear enables. It is instantiated for main and for skid and built on `vDFF_en`.

## Test plan
- Reset: hold `rst` = 0 for 2 cycles with `in_valid` = 1. Required: `out_valid` = 0, `occupancy` = 0, `in_ready` = 1, `imm_out` = 0.
- Streaming: `out_ready` = 1, send imm 1,2,3 on consecutive cycles. Required: `imm_out` = 1,2,3 one cycle later each, `occupancy` stays 1.
- Backpressure: `out_ready` = 0, send imm 0xA, then imm 0xB. Required: `occupancy` = 2 and `in_ready` = 0. Raise `out_ready`: 0xA issues, then 0xB issues, then `in_ready` = 1.
- Flush: with `occupancy` = 2 and `in_valid` = 1 carrying imm 0xC, assert `flush` for one cycle. Required: next cycle `out_valid` = 0, `occupancy` = 0, and 0xC never appears.
- Loads: send `control_in` with bit 8 set, then a bubble. Required: `loads` = 1 for one cycle, then 0.
- Macro undefined: rerun the backpressure scenario. Required: `in_ready` = 0 whenever `out_valid` = 1 and `out_ready` = 0, and `occupancy` ≤ 1.
